// File: rtl/reg_file_wb.sv
// Write-back register file: one decoded write port, two combinational read ports, r0 fixed at 0.
// Define RF_WB_BYPASS_EN to forward the in-flight WB write data onto matching read ports.
module reg_file_wb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NumRegs];
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  assign w_wr_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    w_rd1 = (read_reg1 == '0) ? '0 : r_regs[read_reg1];
    w_rd2 = (read_reg2 == '0) ? '0 : r_regs[read_reg2];
`ifdef RF_WB_BYPASS_EN
    // Forward only outside reset so an asserted rst still reads as zero.
    if (!rst && w_wr_en && (read_reg1 == write_reg)) begin
      w_rd1 = write_data;
    end
    if (!rst && w_wr_en && (read_reg2 == write_reg)) begin
      w_rd2 = write_data;
    end
`endif
  end

  assign read_data1 = w_rd1;
  assign read_data2 = w_rd2;

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomised and directed checks of reg_file_wb against an array-based register model.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int chk_total = 0;
  int chk_bad   = 0;

  logic [31:0] mem [32];

  reg_file_wb #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_total++;
    if (got !== exp) begin
      chk_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    return (ra == 5'd0) ? 32'd0 : mem[ra];
  endfunction

  // Value a read port shows before the edge that commits the current write.
  function automatic logic [31:0] model_pre(input logic [4:0] ra, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] v;
    v = model_read(ra);
`ifdef RF_WB_BYPASS_EN
    if (we && wa != 5'd0 && ra == wa) v = wd;
`endif
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
  endtask

  // One write cycle with reads checked before and after the rising edge.
  task automatic do_cycle(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    reg_write  = we;
    write_reg  = wa;
    write_data = wd;
    read_reg1  = ra1;
    read_reg2  = ra2;
    #1;
    check({tag, "_pre1"}, read_data1, model_pre(ra1, we, wa, wd));
    check({tag, "_pre2"}, read_data2, model_pre(ra2, we, wa, wd));
    @(posedge clk);
    if (we && wa != 5'd0) mem[wa] = wd;
    #1;
    check({tag, "_post1"}, read_data1, model_read(ra1));
    check({tag, "_post2"}, read_data2, model_read(ra2));
    reg_write = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = i[4:0];
      read_reg2 = 5'(31 - i);
      #1;
      check({tag, "_p1"}, read_data1, model_read(i[4:0]));
      check({tag, "_p2"}, read_data2, model_read(5'(31 - i)));
    end
  endtask

  initial begin
    logic        we;
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] wd;

    rst        = 1'b1;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset_init");
    rst = 1'b0;

    // Basic writes on consecutive cycles.
    do_cycle("wr_r1", 1'b1, 5'd1, 32'h0000_0011, 5'd1, 5'd31);
    do_cycle("wr_r31", 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd1, 5'd31);

    // r0 ignores writes.
    do_cycle("wr_r0", 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    do_cycle("r0_hold", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Disabled write leaves r7 unchanged.
    do_cycle("wr_r7", 1'b1, 5'd7, 32'h0000_0077, 5'd7, 5'd7);
    do_cycle("wr_dis", 1'b0, 5'd7, 32'hAAAA_5555, 5'd7, 5'd7);

    // Read of the register being written in the same cycle.
    do_cycle("rw9_a", 1'b1, 5'd9, 32'h0000_0001, 5'd9, 5'd9);
    do_cycle("rw9_b", 1'b1, 5'd9, 32'h0000_0002, 5'd9, 5'd9);

    // Asynchronous reset away from any clock edge.
    do_cycle("wr_r5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd1);
    @(negedge clk);
    read_reg1 = 5'd5;
    read_reg2 = 5'd5;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("async_rst_r5_p1", read_data1, 32'd0);
    check("async_rst_r5_p2", read_data2, 32'd0);
    check_all("async_rst");

    // Write attempted while reset is held: reset wins, no forwarding.
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'h0000_0055;
    read_reg1  = 5'd3;
    read_reg2  = 5'd3;
    #1;
    check("rst_wr_pre", read_data1, 32'd0);
    @(posedge clk);
    #1;
    check("rst_wr_post", read_data2, 32'd0);
    @(negedge clk);
    reg_write = 1'b0;
    rst       = 1'b0;
    check("rst_rel_r3", read_data1, 32'd0);
    do_cycle("first_wr", 1'b1, 5'd3, 32'h0000_0033, 5'd3, 5'd2);

    // Fill every register, then read every pair.
    for (int i = 1; i < 32; i++) begin
      do_cycle("sweep_wr", 1'b1, i[4:0], i * 32'h0101_0101, i[4:0], 5'd0);
    end
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        read_reg1 = a[4:0];
        read_reg2 = b[4:0];
        #1;
        check("sweep_rd1", read_data1, model_read(a[4:0]));
        check("sweep_rd2", read_data2, model_read(b[4:0]));
      end
    end

    // Random traffic with reads biased towards the write target.
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      do_cycle("rand", we, wa, wd, ra1, ra2);
    end
    @(negedge clk);
    check_all("final");

    $display("test done: total=%0d bad=%0d", chk_total, chk_bad);
    $finish;
  end

endmodule
